// File: rtl/unified_mem_arbiter_if.sv
// Bundle of the IF requester, DM requester and memory-port signals of the unified memory arbiter.
interface unified_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);

  // Instruction-fetch requester
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_valid;
  logic              if_stall;

  // MEM-stage data requester
  logic              dm_memread;
  logic              dm_memwrite;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_valid;
  logic              dm_stall;

  // Shared memory port
  logic              m_en;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [DATA_W-1:0] m_rdata;

  // Status
  logic              busy;
  logic              owner;
  logic              err;

  // Arbiter side
  modport slave (
    input  if_req, if_addr,
    input  dm_memread, dm_memwrite, dm_addr, dm_wdata,
    input  m_rdata,
    output if_rdata, if_valid, if_stall,
    output dm_rdata, dm_valid, dm_stall,
    output m_en, m_we, m_addr, m_wdata,
    output busy, owner, err
  );

  // Pipeline and memory side
  modport master (
    output if_req, if_addr,
    output dm_memread, dm_memwrite, dm_addr, dm_wdata,
    output m_rdata,
    input  if_rdata, if_valid, if_stall,
    input  dm_rdata, dm_valid, dm_stall,
    input  m_en, m_we, m_addr, m_wdata,
    input  busy, owner, err
  );

endinterface

// File: rtl/unified_mem_arbiter.sv
// Shares one single-ported fixed-latency memory between instruction fetch and data access.
// Accesses are serialised IDLE -> ISSUE -> (WAIT) -> DONE; DM has priority unless IF has
// waited through STARVE_LIMIT consecutive DM grants.
module unified_mem_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned MEM_LATENCY  = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  unified_mem_arbiter_if.slave  bus
);

  // Latency and starvation counters both cover the legal 1..15 range
  localparam int unsigned      CNT_W      = 4;
  localparam logic [CNT_W-1:0] LAT_LOAD   = CNT_W'(MEM_LATENCY);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  lat_cnt;
  logic [CNT_W-1:0]  starve_cnt;

  // Latched access
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              we;
  logic              en;

  // Registered completion and status
  logic [DATA_W-1:0] if_rdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              if_valid;
  logic              dm_valid;
  logic              busy;
  logic              owner;
  logic              err;

  logic              dm_req;
  logic              if_forced;
  logic              grant_if;

  // Arbitration decision, only acted upon in IDLE
  assign dm_req    = bus.dm_memread | bus.dm_memwrite;
  assign if_forced = (starve_cnt == STARVE_MAX);
  assign grant_if  = bus.if_req & (~dm_req | if_forced);

  // Access sequencer: grant, issue strobe, latency count, completion pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      lat_cnt    <= '0;
      starve_cnt <= '0;
      addr       <= '0;
      wdata      <= '0;
      we         <= 1'b0;
      en         <= 1'b0;
      if_rdata   <= '0;
      dm_rdata   <= '0;
      if_valid   <= 1'b0;
      dm_valid   <= 1'b0;
      busy       <= 1'b0;
      owner      <= 1'b0;
      err        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          // An idle cycle without a fetch pending ends any starvation streak
          if (!bus.if_req) begin
            starve_cnt <= '0;
          end
          if (grant_if) begin
            owner      <= 1'b0;
            addr       <= bus.if_addr;
            we         <= 1'b0;
            starve_cnt <= '0;
            en         <= 1'b1;
            busy       <= 1'b1;
            state      <= S_ISSUE;
          end else if (dm_req) begin
            owner <= 1'b1;
            addr  <= bus.dm_addr;
            wdata <= bus.dm_wdata;
            // Conflicting load+store is resolved as a store and flagged
            we    <= bus.dm_memwrite;
            if (bus.dm_memread && bus.dm_memwrite) begin
              err <= 1'b1;
            end
            if (bus.if_req) begin
              starve_cnt <= starve_cnt + CNT_ONE;
            end
            en    <= 1'b1;
            busy  <= 1'b1;
            state <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          en <= 1'b0;
          if (we) begin
            // Stores complete without waiting on read data
            if (owner) begin
              dm_valid <= 1'b1;
            end else begin
              if_valid <= 1'b1;
            end
            state <= S_DONE;
          end else begin
            lat_cnt <= LAT_LOAD;
            state   <= S_WAIT;
          end
        end

        S_WAIT: begin
          lat_cnt <= lat_cnt - CNT_ONE;
          if (lat_cnt == CNT_ONE) begin
            // Only the owner's read register is refreshed
            if (owner) begin
              dm_rdata <= bus.m_rdata;
              dm_valid <= 1'b1;
            end else begin
              if_rdata <= bus.m_rdata;
              if_valid <= 1'b1;
            end
            state <= S_DONE;
          end
        end

        S_DONE: begin
          // No grant here: the just-served request may still be held this cycle
          if_valid <= 1'b0;
          dm_valid <= 1'b0;
          busy     <= 1'b0;
          state    <= S_IDLE;
        end

        default: begin
          en    <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Memory port carries the latched access; contents are only meaningful while m_en is high
  assign bus.m_en    = en;
  assign bus.m_we    = we;
  assign bus.m_addr  = addr;
  assign bus.m_wdata = wdata;

  // Requester-facing completion and status
  assign bus.if_rdata = if_rdata;
  assign bus.dm_rdata = dm_rdata;
  assign bus.if_valid = if_valid;
  assign bus.dm_valid = dm_valid;
  assign bus.busy     = busy;
  assign bus.owner    = owner;
  assign bus.err      = err;

  // Stalls release in the valid cycle so the pipeline advances at the edge ending it
  assign bus.if_stall = bus.if_req & ~if_valid;
  assign bus.dm_stall = dm_req & ~dm_valid;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Randomised self-checking bench for unified_mem_arbiter against a transaction-level model.
module tb_unified_mem_arbiter;

  localparam int ML = 2;
  localparam int SL = 2;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  unified_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  unified_mem_arbiter #(
    .ADDR_W      (32),
    .DATA_W      (32),
    .MEM_LATENCY (ML),
    .STARVE_LIMIT(SL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Requester behaviour
  bit          if_pend, dm_pend, dm_rd, dm_wr;
  logic [31:0] if_a, dm_a, dm_wd;
  int          if_rate, dm_rate, dm_mode;

  // Memory read data source
  logic [31:0] rd_hist [int];
  logic [31:0] rd_force;
  int          rd_force_cyc = -1;

  // Reference model: at most one access in flight, described by grant cycle and length
  bit          have_acc, acc_own, acc_we;
  int          acc_g, acc_len;
  logic [31:0] acc_a, acc_wd;
  int          starve;
  bit          exp_err, exp_owner;
  logic [31:0] exp_if_rd, exp_dm_rd;
  bit          last_if_v, last_dm_v;
  bit          grant_log [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s (cycle %0d): got %0h expected %0h", tag, cyc, got, exp);
  endtask

  task automatic model_reset();
    have_acc = 0; acc_own = 0; acc_we = 0; acc_g = 0; acc_len = 0;
    acc_a = '0; acc_wd = '0;
    starve = 0; exp_err = 0; exp_owner = 0;
    exp_if_rd = '0; exp_dm_rd = '0;
    last_if_v = 0; last_dm_v = 0;
    if_pend = 0; dm_pend = 0; dm_rd = 0; dm_wr = 0;
    if_a = '0; dm_a = '0; dm_wd = '0;
    if_rate = 0; dm_rate = 0;
  endtask

  task automatic drive();
    bus.if_req      = if_pend;
    bus.if_addr     = if_pend ? if_a : $urandom;
    bus.dm_memread  = dm_pend & dm_rd;
    bus.dm_memwrite = dm_pend & dm_wr;
    bus.dm_addr     = dm_pend ? dm_a : $urandom;
    bus.dm_wdata    = dm_pend ? dm_wd : $urandom;
  endtask

  // Requests are held until their valid cycle, then may be replaced next cycle
  task automatic update_requesters();
    if (if_pend && last_if_v) if_pend = 0;
    if (dm_pend && last_dm_v) dm_pend = 0;
    if (!if_pend && int'($urandom_range(99)) < if_rate) begin
      if_pend = 1;
      if_a    = $urandom;
    end
    if (!dm_pend && int'($urandom_range(99)) < dm_rate) begin
      dm_pend = 1;
      dm_a    = $urandom;
      dm_wd   = $urandom;
      case (dm_mode)
        1:       begin dm_rd = 1; dm_wr = 0; end
        2:       begin dm_rd = 0; dm_wr = 1; end
        default: begin dm_rd = ($urandom_range(1) == 1); dm_wr = !dm_rd; end
      endcase
    end
  endtask

  task automatic start_acc(input bit own, input bit w, input logic [31:0] a, input logic [31:0] d);
    have_acc  = 1;
    acc_g     = cyc;
    acc_own   = own;
    acc_we    = w;
    acc_a     = a;
    acc_wd    = d;
    acc_len   = w ? 3 : ML + 3;
    exp_owner = own;
  endtask

  // Arbitration rules applied in any cycle where no access is in flight
  task automatic model_step();
    if (!have_acc || cyc >= acc_g + acc_len) begin
      if (!if_pend) starve = 0;
      if (if_pend && (!dm_pend || starve == SL)) begin
        starve = 0;
        start_acc(0, 0, if_a, '0);
      end else if (dm_pend) begin
        if (if_pend) starve++;
        if (dm_rd && dm_wr) exp_err = 1;
        start_acc(1, dm_wr, dm_a, dm_wd);
      end
    end
  endtask

  task automatic check_cycle();
    bit v, men, busy_e;
    v      = have_acc && (cyc == acc_g + acc_len - 1);
    men    = have_acc && (cyc == acc_g + 1);
    busy_e = have_acc && (cyc > acc_g) && (cyc < acc_g + acc_len);
    // Read data is the memory value present in the cycle before the valid pulse
    if (v && !acc_we) begin
      if (acc_own) exp_dm_rd = rd_hist[cyc-1];
      else         exp_if_rd = rd_hist[cyc-1];
    end
    check("if_valid", 64'(bus.if_valid), 64'(v && !acc_own));
    check("dm_valid", 64'(bus.dm_valid), 64'(v && acc_own));
    check("m_en", 64'(bus.m_en), 64'(men));
    if (bus.m_en) grant_log.push_back(bus.owner);
    if (men) begin
      check("m_we", 64'(bus.m_we), 64'(acc_we));
      check("m_addr", 64'(bus.m_addr), 64'(acc_a));
      if (acc_we) check("m_wdata", 64'(bus.m_wdata), 64'(acc_wd));
    end
    check("busy", 64'(bus.busy), 64'(busy_e));
    check("owner", 64'(bus.owner), 64'(exp_owner));
    check("err", 64'(bus.err), 64'(exp_err));
    check("if_rdata", 64'(bus.if_rdata), 64'(exp_if_rd));
    check("dm_rdata", 64'(bus.dm_rdata), 64'(exp_dm_rd));
    check("if_stall", 64'(bus.if_stall), 64'(if_pend && !(v && !acc_own)));
    check("dm_stall", 64'(bus.dm_stall), 64'(dm_pend && !(v && acc_own)));
    last_if_v = v && !acc_own;
    last_dm_v = v && acc_own;
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      update_requesters();
      drive();
      bus.m_rdata = (cyc == rd_force_cyc) ? rd_force : $urandom;
      rd_hist[cyc] = bus.m_rdata;
      @(negedge clk);
      check_cycle();
      model_step();
      cyc++;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    if_rate = 0;
    dm_rate = 0;
    while ((if_pend || dm_pend || (have_acc && cyc < acc_g + acc_len)) && n < 200) begin
      run_cycles(1);
      n++;
    end
    check("drain_bound", 64'(n < 200), 64'(1));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_if_rdata"}, 64'(bus.if_rdata), 64'(0));
    check({tag, "_dm_rdata"}, 64'(bus.dm_rdata), 64'(0));
    check({tag, "_if_valid"}, 64'(bus.if_valid), 64'(0));
    check({tag, "_dm_valid"}, 64'(bus.dm_valid), 64'(0));
    check({tag, "_m_en"}, 64'(bus.m_en), 64'(0));
    check({tag, "_m_we"}, 64'(bus.m_we), 64'(0));
    check({tag, "_m_addr"}, 64'(bus.m_addr), 64'(0));
    check({tag, "_m_wdata"}, 64'(bus.m_wdata), 64'(0));
    check({tag, "_busy"}, 64'(bus.busy), 64'(0));
    check({tag, "_owner"}, 64'(bus.owner), 64'(0));
    check({tag, "_err"}, 64'(bus.err), 64'(0));
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    model_reset();
    drive();
    bus.m_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero(tag);
    rst = 1'b0;
  endtask

  initial begin
    bit exp_order [6];
    exp_order = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    dm_mode = 0;
    do_reset("por");

    // Fetch read with a known memory word
    rd_force     = 32'hDEADBEEF;
    rd_force_cyc = cyc + 3;
    if_pend = 1; if_a = 32'h40;
    run_cycles(8);
    check("if_read_data", 64'(bus.if_rdata), 64'(32'hDEADBEEF));

    // Store; fetch data register must not change
    dm_pend = 1; dm_rd = 0; dm_wr = 1; dm_a = 32'h100; dm_wd = 32'h1234;
    run_cycles(6);
    check("store_if_rdata_kept", 64'(bus.if_rdata), 64'(32'hDEADBEEF));

    // Simultaneous requests: DM goes first
    grant_log.delete();
    if_pend = 1; if_a = 32'h80;
    dm_pend = 1; dm_rd = 1; dm_wr = 0; dm_a = 32'h200; dm_wd = 32'h0;
    run_cycles(14);
    check("simul_grants", 64'(grant_log.size()), 64'(2));
    if (grant_log.size() >= 2) begin
      check("simul_first", 64'(grant_log[0]), 64'(1));
      check("simul_second", 64'(grant_log[1]), 64'(0));
    end
    drain();

    // Starvation: continuous loads and fetches
    run_cycles(3);
    grant_log.delete();
    dm_mode = 1; if_rate = 100; dm_rate = 100;
    run_cycles(28);
    drain();
    check("starve_grants", 64'(grant_log.size() >= 6), 64'(1));
    if (grant_log.size() >= 6) begin
      for (int i = 0; i < 6; i++) check($sformatf("starve_order%0d", i), 64'(grant_log[i]), 64'(exp_order[i]));
    end

    // Conflicting load+store: performed as a store, err is sticky
    dm_pend = 1; dm_rd = 1; dm_wr = 1; dm_a = 32'h300; dm_wd = 32'hA5A5;
    run_cycles(6);
    check("err_set", 64'(bus.err), 64'(1));
    dm_mode = 0; if_rate = 30; dm_rate = 30;
    run_cycles(200);
    drain();
    check("err_sticky", 64'(bus.err), 64'(1));
    do_reset("err_rst");

    // Random mixed traffic
    dm_mode = 0; if_rate = 35; dm_rate = 35;
    run_cycles(1200);
    drain();

    // Reset in WAIT: outputs drop without a clock edge
    if_pend = 1; if_a = 32'h40;
    run_cycles(2);
    @(posedge clk); #1;
    check("wait_busy_pre", 64'(bus.busy), 64'(1));
    rst = 1'b1;
    #1;
    check("wait_rst_m_en", 64'(bus.m_en), 64'(0));
    check("wait_rst_busy", 64'(bus.busy), 64'(0));
    check("wait_rst_if_valid", 64'(bus.if_valid), 64'(0));
    check("wait_rst_dm_valid", 64'(bus.dm_valid), 64'(0));
    do_reset("wait_rst");
    run_cycles(10);
    check_zero("wait_post");

    // Reset in ISSUE: active strobe drops immediately
    dm_pend = 1; dm_rd = 0; dm_wr = 1; dm_a = 32'h1F0; dm_wd = 32'h5555;
    run_cycles(1);
    @(posedge clk); #1;
    check("issue_m_en_pre", 64'(bus.m_en), 64'(1));
    rst = 1'b1;
    #1;
    check("issue_rst_m_en", 64'(bus.m_en), 64'(0));
    check("issue_rst_busy", 64'(bus.busy), 64'(0));
    do_reset("issue_rst");
    run_cycles(6);

    // More random traffic after reset
    dm_mode = 0; if_rate = 50; dm_rate = 50;
    run_cycles(600);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/unified_mem_arbiter.md
# unified_mem_arbiter

Shares one single-ported, fixed-latency unified memory between the instruction-fetch requester (IF stage) and the data requester (MEM stage, lw/sw). It serialises accesses with a four-state FSM, returns registered read data with a one-cycle valid pulse, and drives per-requester stall lines. The pipeline control logic ORs these stall lines into PC/IF_ID write-enable and bubble insertion.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LATENCY, 2, cycles from the memory issue cycle to valid m_rdata; legal range 1..15
- STARVE_LIMIT, 4, consecutive DM grants allowed while if_req is pending before IF is forced; legal range 1..15

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- if_req  in  1  instruction fetch request
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  fetched word, registered
- if_valid  out  1  fetch completion pulse
- if_stall  out  1  if_req & ~if_valid
- dm_memread  in  1  MEM-stage load request
- dm_memwrite  in  1  MEM-stage store request
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  store data
- dm_rdata  out  DATA_W  load data, registered
- dm_valid  out  1  data completion pulse
- dm_stall  out  1  (dm_memread|dm_memwrite) & ~dm_valid
- m_en  out  1  memory access strobe
- m_we  out  1  memory write enable
- m_addr  out  ADDR_W  memory address
- m_wdata  out  DATA_W  memory write data
- m_rdata  in  DATA_W  memory read data
- busy  out  1  state != IDLE
- owner  out  1  current or last grant: 0 = IF, 1 = DM
- err  out  1  sticky: dm_memread & dm_memwrite sampled together at a grant

## Operation
- dm_req = dm_memread | dm_memwrite.
- Requesters hold their request, address, and data stable until their valid pulse.
- States:
  - IDLE: if any request is pending, grant one, latch the address, wdata, and we (we = dm_memwrite for DM, 0 for IF), then go to ISSUE.
  - ISSUE: m_en = 1 for exactly one cycle with the latched values. Read: load counter = MEM_LATENCY, go to WAIT. Write: go to DONE.
  - WAIT: decrement the counter each cycle. In the cycle the counter equals 1, capture m_rdata into the owner's rdata register and go to DONE.
  - DONE: assert the owner's valid for one cycle. No grant is evaluated here, so a request the pipeline is still holding for the just-served access is never re-granted. Go to IDLE.
- Arbitration in IDLE:
  - DM has priority over IF.
  - Exception: when starve_cnt == STARVE_LIMIT and if_req is high, IF wins.
  - starve_cnt increments on each DM grant made while if_req is high.
  - starve_cnt clears on an IF grant, or on any IDLE cycle with if_req low.
- If dm_memread and dm_memwrite are both high at a DM grant, the access is treated as a write and err is set. err clears only on rst.
- A request dropped mid-access does not abort the access. The access completes and the valid pulse still fires.
- Unserved rdata registers hold their value. Only the owner's register is updated.
- m_we, m_addr, and m_wdata are don't-care when m_en = 0; hold them at their latched values.

## Timing
- Reset values: state IDLE. All outputs 0: rdata registers, valids, m_en, m_we, m_addr, m_wdata, busy, owner, err. starve_cnt = 0.
- Reset asserted mid-access abandons the access immediately, with m_en forced low asynchronously. No valid pulse follows.
- Request first sampled at edge E0 in IDLE:
  - ISSUE occupies cycle E0+1.
  - Read: m_rdata is sampled at the end of cycle E0+MEM_LATENCY+1, and valid is high in cycle E0+MEM_LATENCY+2.
  - Write: valid is high in cycle E0+2.
- Occupancy: a read takes MEM_LATENCY+3 cycles including IDLE; a write takes 3.
- Stalls are combinational from the request and valid inputs. Stall is low in the valid cycle, so the pipeline advances at the edge ending that cycle.
- The losing requester stays stalled across the whole winning access plus its own.

## Test plan
- Reset: assert rst mid-WAIT. Required: m_en, busy, and the valids drop without waiting for a clock edge. After release, no if_valid or dm_valid appears and all outputs are 0.
- IF read, MEM_LATENCY = 2, if_addr = 0x40, m_rdata = 0xDEADBEEF in cycle 3. Required: m_en = 1 and m_addr = 0x40 in cycle 1; if_valid = 1 and if_rdata = 0xDEADBEEF in cycle 4; if_stall high in cycles 0–3 and low in cycle 4.
- Store: dm_memwrite, dm_addr = 0x100, dm_wdata = 0x1234. Required: m_en = m_we = 1 with those values in cycle 1; dm_valid in cycle 2; if_rdata unchanged.
- Simultaneous: if_req and dm_memread both high in cycle 0. Required: the DM access runs first (owner = 1); the IF ISSUE occurs in the cycle after DM's DONE+IDLE; if_stall stays high throughout.
- Starvation, STARVE_LIMIT = 2, continuous dm_memread and if_req. Required grant order: DM, DM, IF, DM, DM, IF.
- Error: dm_memread and dm_memwrite both high at grant. Required: a write is performed (m_we = 1), err = 1, and err stays 1 until rst.
